// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILISE,
    RUN,
    LOST,
    FAULT,
    BYPASS_RUN
  } pll_state_e;

  localparam int RETRY_W = 4;

  // The single phase counter must hold the largest per-phase cycle count;
  // one spare bit keeps the terminal-count compare clear of wrap-around.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a selectable synchronous reset value.
// Also suitable for bringing a reset request into another clock domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic sresetn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_i) begin
    if (!sresetn_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-loss sequencer running on the free-running reference
// clock. Holds downstream reset until lock has been stable, retries on lock
// timeout and reports a fault once retries are exhausted.
// Optional build macro PLL_SEQ_BYPASS_FALLBACK_EN: on retry exhaustion run the
// system from the bypassed PLL (degraded) instead of stopping in FAULT.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clk,
  input  logic               sresetn,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               sys_resetn,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int RW1   = RETRY_W + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RW1-1:0]   RETRY_LIMIT = RW1'(MAX_RETRIES);

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  localparam pll_state_e EXHAUSTED = BYPASS_RUN;
`else
  localparam pll_state_e EXHAUSTED = FAULT;
`endif

  // The failure count is reported saturated; the exhaustion compare uses the
  // unsaturated value so MAX_RETRIES=15 still reaches the terminal state.
  function automatic logic [RETRY_W-1:0] sat_retry(input logic [RW1-1:0] v);
    return v[RETRY_W] ? {RETRY_W{1'b1}} : v[RETRY_W-1:0];
  endfunction

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RW1-1:0]     fails;
  logic               lock_s;
  logic               resetb_q, resetb_d;
  logic               sysrst_q, sysrst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk_i     (clk),
    .sresetn_i (sresetn),
    .d_i       (pll_locked),
    .q_o       (lock_s)
  );

  // Next state, retry bookkeeping and the shared phase counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fails   = {1'b0, retry_q} + RW1'(1);
    case (state_q)
      RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILISE;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = sat_retry(fails);
          state_d = (fails > RETRY_LIMIT) ? EXHAUSTED : RESET_PLL;
        end
      end
      STABILISE: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = RUN;
      end
      RUN:     if (!lock_s) state_d = LOST;
      LOST:    state_d = RESET_PLL;
      default: state_d = state_q;
    endcase
    // A restart beats any same-cycle timeout and begins a fresh sequence.
    if (restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (state_q inside {RESET_PLL, WAIT_LOCK, STABILISE}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  logic bypass_q, bypass_d;
`endif

  // Output decode from the next state so every pin is a plain flop.
  always_comb begin
    resetb_d = 1'b1;
    sysrst_d = 1'b0;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    bypass_d = 1'b0;
`endif
    case (state_d)
      RESET_PLL: resetb_d = 1'b0;
      RUN: begin
        sysrst_d = 1'b1;
        ready_d  = 1'b1;
      end
      FAULT: begin
        resetb_d = 1'b0;
        fault_d  = 1'b1;
      end
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      BYPASS_RUN: begin
        sysrst_d = 1'b1;
        fault_d  = 1'b1;
        bypass_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q  <= RESET_PLL;
      cnt_q    <= '0;
      retry_q  <= '0;
      resetb_q <= 1'b0;
      sysrst_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      resetb_q <= resetb_d;
      sysrst_q <= sysrst_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
      bypass_q <= bypass_d;
`endif
    end
  end

  assign pll_resetb  = resetb_q;
  assign sys_resetn  = sysrst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  assign pll_bypass  = bypass_q;
`else
  assign pll_bypass  = 1'b0;
`endif

endmodule
